// File: rtl/mix_pkg.sv
// rtl/mix_pkg.sv - shared widths, drain state encoding and saturation limits for mix_out_buffer
package mix_pkg;

    localparam int MIX_W = 11;
    localparam int AUD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        GAP  = 2'd2
    } drain_state_t;

    localparam logic [AUD_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [AUD_W-1:0] SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/mix_sample_fifo.sv
// rtl/mix_sample_fifo.sv - synchronous sample FIFO; a push into a full FIFO is accepted only alongside a pop
module mix_sample_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [W-1:0]             push_data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic          push_ok;
    logic          pop_ok;

    assign full_o     = (level_q == FULL_LVL);
    assign empty_o    = (level_q == '0);
    assign pop_ok     = pop_i && !empty_o;
    assign push_ok    = push_i && (!full_o || pop_ok);
    assign pop_data_o = mem_q[rd_ptr_q];
    assign level_o    = level_q;

    // When full, wr_ptr equals rd_ptr; the head is read combinationally before this edge overwrites it.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/mix_out_buffer.sv
// rtl/mix_out_buffer.sv - mixer sum to codec: recentre, saturating gain, FIFO, 3-cycle drain handshake
// Optional drop_count port and counter under MIX_DROP_CNT_EN.
module mix_out_buffer
    import mix_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int GAIN_SHIFT = 16,
    parameter int MID_OFFSET = 1020
) (
    input  logic                          CLOCK_50,
    input  logic                          resetn,
    input  logic [MIX_W-1:0]              mix_in,
    input  logic                          mix_valid,
    input  logic                          audio_out_allowed,
    output logic [AUD_W-1:0]              left_channel_audio_out,
    output logic [AUD_W-1:0]              right_channel_audio_out,
    output logic                          write_audio_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef MIX_DROP_CNT_EN
    ,
    output logic [15:0]                   drop_count
`endif
);

    localparam logic signed [11:0] MID_S = 12'(MID_OFFSET);
    localparam logic signed [35:0] P_MAX = {4'h0, SAT_MAX};
    localparam logic signed [35:0] P_MIN = {4'hF, SAT_MIN};

    logic signed [11:0] centred_w;
    logic signed [35:0] scaled_w;
    logic [AUD_W-1:0]   sample_d;
    logic [AUD_W-1:0]   conv_data_q;
    logic               conv_valid_q;
    drain_state_t       state_q;
    logic [AUD_W-1:0]   left_q;
    logic               write_q;
    logic [AUD_W-1:0]   fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop_w;
    logic               push_w;

    always_comb begin
        centred_w = $signed({1'b0, mix_in}) - MID_S;
        scaled_w  = 36'({{24{centred_w[11]}}, centred_w} << GAIN_SHIFT);
        if (scaled_w > P_MAX) begin
            sample_d = SAT_MAX;
        end else if (scaled_w < P_MIN) begin
            sample_d = SAT_MIN;
        end else begin
            sample_d = scaled_w[AUD_W-1:0];
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            conv_valid_q <= 1'b0;
            conv_data_q  <= '0;
        end else begin
            conv_valid_q <= mix_valid;
            if (mix_valid) conv_data_q <= sample_d;
        end
    end

    assign pop_w  = (state_q == IDLE) && !fifo_empty && audio_out_allowed;
    assign push_w = conv_valid_q && (!fifo_full || pop_w);

    mix_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (AUD_W)
    ) u_fifo (
        .clk_i       (CLOCK_50),
        .rst_ni      (resetn),
        .push_i      (push_w),
        .push_data_i (conv_data_q),
        .pop_i       (pop_w),
        .pop_data_o  (fifo_rdata),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level)
    );

    // GAP gives the codec one cycle to refresh audio_out_allowed before the next pop.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            left_q  <= '0;
            write_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop_w) begin
                        left_q  <= fifo_rdata;
                        write_q <= 1'b1;
                        state_q <= WR;
                    end
                end
                WR: begin
                    write_q <= 1'b0;
                    state_q <= GAP;
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    write_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign left_channel_audio_out  = left_q;
    assign right_channel_audio_out = left_q;
    assign write_audio_out         = write_q;

`ifdef MIX_DROP_CNT_EN
    logic        drop_w;
    logic [15:0] drop_cnt_q;

    assign drop_w = conv_valid_q && fifo_full && !pop_w;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            drop_cnt_q <= '0;
        end else if (drop_w && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_mix_out_buffer.sv
// tb/tb_mix_out_buffer.sv - directed self-checking bench for mix_out_buffer (gain 16 and gain 22 instances)
module tb_mix_out_buffer;

    logic        CLOCK_50 = 1'b0;
    logic        resetn;
    logic [10:0] mix_in;
    logic        mix_valid;
    logic        audio_out_allowed;

    logic [31:0] l1, r1, l2, r2;
    logic        w1, w2;
    logic [3:0]  lvl1, lvl2;
`ifdef MIX_DROP_CNT_EN
    logic [15:0] dc1, dc2;
`endif

    int ncomp = 0;
    int nfail = 0;
    int cyc   = 0;
    logic [31:0] log_d[$];
    int          log_c[$];

    mix_out_buffer #(.FIFO_DEPTH(8), .GAIN_SHIFT(16), .MID_OFFSET(1020)) dut16 (
        .CLOCK_50                (CLOCK_50),
        .resetn                  (resetn),
        .mix_in                  (mix_in),
        .mix_valid               (mix_valid),
        .audio_out_allowed       (audio_out_allowed),
        .left_channel_audio_out  (l1),
        .right_channel_audio_out (r1),
        .write_audio_out         (w1),
        .fifo_level              (lvl1)
`ifdef MIX_DROP_CNT_EN
        ,
        .drop_count              (dc1)
`endif
    );

    mix_out_buffer #(.FIFO_DEPTH(8), .GAIN_SHIFT(22), .MID_OFFSET(1020)) dut22 (
        .CLOCK_50                (CLOCK_50),
        .resetn                  (resetn),
        .mix_in                  (mix_in),
        .mix_valid               (mix_valid),
        .audio_out_allowed       (audio_out_allowed),
        .left_channel_audio_out  (l2),
        .right_channel_audio_out (r2),
        .write_audio_out         (w2),
        .fifo_level              (lvl2)
`ifdef MIX_DROP_CNT_EN
        ,
        .drop_count              (dc2)
`endif
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    always @(negedge CLOCK_50) begin
        if (w1 === 1'b1) begin
            log_d.push_back(l1);
            log_c.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_and_check(input string tag, input logic [10:0] v,
                                  input logic [31:0] e16, input logic [31:0] e22);
        mix_in    = v;
        mix_valid = 1'b1;
        tick();
        mix_valid = 1'b0;
        tick();
        check({tag, "_n2_nowrite"}, 32'(w1), 32'd0);
        tick();
        check({tag, "_n3_write"}, 32'(w1), 32'd1);
        check({tag, "_left16"}, l1, e16);
        check({tag, "_right16"}, r1, e16);
        check({tag, "_left22"}, l2, e22);
        check({tag, "_right22"}, r2, e22);
        tick();
    endtask

    task automatic pulses(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            mix_in    = 11'(base + i);
            mix_valid = 1'b1;
            tick();
        end
        mix_valid = 1'b0;
    endtask

    initial begin
        int k;
        resetn            = 1'b0;
        mix_in            = 11'd500;
        mix_valid         = 1'b1;
        audio_out_allowed = 1'b1;
        ticks(3);
        check("rst_write", 32'(w1), 32'd0);
        check("rst_left", l1, 32'd0);
        check("rst_right", r1, 32'd0);
        check("rst_level", 32'(lvl1), 32'd0);
`ifdef MIX_DROP_CNT_EN
        check("rst_drops", 32'(dc1), 32'd0);
`endif
        resetn    = 1'b1;
        mix_valid = 1'b0;
        ticks(6);
        check("rst_no_write", 32'(log_d.size()), 32'd0);

        send_and_check("mid", 11'd1020, 32'h0000_0000, 32'h0000_0000);
        send_and_check("max", 11'd2040, 32'h03FC_0000, 32'h7FFF_FFFF);
        send_and_check("min", 11'd0,    32'hFC04_0000, 32'h8000_0000);

        audio_out_allowed = 1'b0;
        ticks(2);
        log_d.delete();
        log_c.delete();
        pulses(10, 100);
        ticks(3);
        check("bp_level", 32'(lvl1), 32'd8);
`ifdef MIX_DROP_CNT_EN
        check("bp_drops", 32'(dc1), 32'd2);
`endif
        audio_out_allowed = 1'b1;
        ticks(30);
        check("bp_count", 32'(log_d.size()), 32'd8);
        for (int i = 0; i < 8 && i < log_d.size(); i++) begin
            check($sformatf("bp_data%0d", i), log_d[i], 32'((100 + i - 1020) * 65536));
            if (i > 0) check($sformatf("bp_gap%0d", i), 32'(log_c[i] - log_c[i-1]), 32'd3);
        end
        check("bp_drained", 32'(lvl1), 32'd0);

        audio_out_allowed = 1'b0;
        pulses(8, 200);
        ticks(3);
        check("pp_fill", 32'(lvl1), 32'd8);
        log_d.delete();
        log_c.delete();
        mix_in    = 11'd300;
        mix_valid = 1'b1;
        tick();
        mix_valid         = 1'b0;
        audio_out_allowed = 1'b1;
        tick();
        check("pp_write", 32'(w1), 32'd1);
        check("pp_level", 32'(lvl1), 32'd8);
        check("pp_head", l1, 32'((200 - 1020) * 65536));
`ifdef MIX_DROP_CNT_EN
        check("pp_drops", 32'(dc1), 32'd2);
`endif
        ticks(30);
        check("pp_count", 32'(log_d.size()), 32'd9);
        if (log_d.size() == 9) check("pp_last", log_d[8], 32'((300 - 1020) * 65536));

        audio_out_allowed = 1'b0;
        pulses(5, 400);
        ticks(3);
        check("mr_fill", 32'(lvl1), 32'd5);
        audio_out_allowed = 1'b1;
        k = 0;
        while (w1 !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check("mr_wr_seen", 32'(w1), 32'd1);
        resetn = 1'b0;
        #1;
        check("mr_write", 32'(w1), 32'd0);
        check("mr_level", 32'(lvl1), 32'd0);
        check("mr_left", l1, 32'd0);
        check("mr_right", r1, 32'd0);
        tick();
        resetn = 1'b1;
        log_d.delete();
        log_c.delete();
        ticks(10);
        check("mr_no_stale", 32'(log_d.size()), 32'd0);
        check("mr_level_after", 32'(lvl1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
